// File: rtl/cache_types_pkg.sv
// Shared constants and state encoding for the cache-line <-> burst-memory adaptor.
// The line geometry here is the default for every module that imports this package.
package cache_types_pkg;

  localparam int CACHE_LINE_W   = 256;
  localparam int CACHE_BURST_W  = 64;
  localparam int CACHE_BEATS    = CACHE_LINE_W / CACHE_BURST_W;
  localparam int CACHE_OFFSET_W = $clog2(CACHE_LINE_W / 8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adaptor_state_e;

endpackage

// File: rtl/line_beat_buffer.sv
// One cache line held as BEATS independent beat registers: full-line load,
// per-beat load enables and a beat-select read mux.
module line_beat_buffer import cache_types_pkg::*; #(
  parameter int LINE_W  = CACHE_LINE_W,
  parameter int BURST_W = CACHE_BURST_W,
  parameter int BEATS   = LINE_W / BURST_W,
  parameter int SEL_W   = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               line_load,
  input  logic [LINE_W-1:0]  line_data,
  input  logic [BEATS-1:0]   beat_load,
  input  logic [BURST_W-1:0] beat_data,
  input  logic [SEL_W-1:0]   beat_sel,
  output logic [BURST_W-1:0] beat_q,
  output logic [LINE_W-1:0]  line_q
);

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_beat
      logic [BURST_W-1:0] beat_reg;

      // A full-line load wins over a single-beat load in the same cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          beat_reg <= '0;
        end else if (line_load) begin
          beat_reg <= line_data[gi*BURST_W +: BURST_W];
        end else if (beat_load[gi]) begin
          beat_reg <= beat_data;
        end
      end

      assign line_q[gi*BURST_W +: BURST_W] = beat_reg;
    end
  endgenerate

  always_comb begin
    beat_q = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (beat_sel == SEL_W'(i)) begin
        beat_q = line_q[i*BURST_W +: BURST_W];
      end
    end
  end

endmodule

// File: rtl/cacheline_adaptor.sv
// Converts single-cycle cache line requests into BEATS-long memory bursts,
// assembling read beats into a line and serialising write lines into beats.
module cacheline_adaptor import cache_types_pkg::*; #(
  parameter int LINE_W  = CACHE_LINE_W,
  parameter int BURST_W = CACHE_BURST_W,
  parameter int BEATS   = LINE_W / BURST_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pmem_read,
  input  logic               pmem_write,
  input  logic [31:0]        pmem_address,
  input  logic [LINE_W-1:0]  pmem_wdata,
  output logic [LINE_W-1:0]  pmem_rdata,
  output logic               pmem_resp,
  output logic               burst_read,
  output logic               burst_write,
  output logic [31:0]        burst_address,
  output logic [BURST_W-1:0] burst_wdata,
  input  logic [BURST_W-1:0] burst_rdata,
  input  logic               burst_resp
);

  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFSET_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  adaptor_state_e     state_reg, state_next;
  logic [CNT_W-1:0]   beat_cnt_reg, beat_cnt_next;
  logic [31:0]        burst_address_reg;
  logic [LINE_W-1:0]  pmem_rdata_reg;

  logic               start_txn;
  logic               line_load;
  logic               last_read_beat;
  logic [BEATS-1:0]   beat_load;
  logic [BURST_W-1:0] buf_beat_q;
  logic [LINE_W-1:0]  buf_line_q;

  line_beat_buffer #(
    .LINE_W  (LINE_W),
    .BURST_W (BURST_W),
    .BEATS   (BEATS),
    .SEL_W   (CNT_W)
  ) u_line_buf (
    .clk       (clk),
    .rst       (rst),
    .line_load (line_load),
    .line_data (pmem_wdata),
    .beat_load (beat_load),
    .beat_data (burst_rdata),
    .beat_sel  (beat_cnt_reg),
    .beat_q    (buf_beat_q),
    .line_q    (buf_line_q)
  );

  always_comb begin
    state_next     = state_reg;
    beat_cnt_next  = beat_cnt_reg;
    start_txn      = 1'b0;
    line_load      = 1'b0;
    last_read_beat = 1'b0;
    beat_load      = '0;

    case (state_reg)
      IDLE: begin
        // Read has priority when both requests arrive together.
        if (pmem_read) begin
          state_next = READ;
          start_txn  = 1'b1;
        end else if (pmem_write) begin
          state_next = WRITE;
          start_txn  = 1'b1;
          line_load  = 1'b1;
        end
      end
      READ: begin
        if (burst_resp) begin
          beat_load[beat_cnt_reg] = 1'b1;
          beat_cnt_next           = beat_cnt_reg + 1'b1;
          if (beat_cnt_reg == LAST_BEAT) begin
            state_next     = DONE;
            beat_cnt_next  = '0;
            last_read_beat = 1'b1;
          end
        end
      end
      WRITE: begin
        if (burst_resp) begin
          beat_cnt_next = beat_cnt_reg + 1'b1;
          if (beat_cnt_reg == LAST_BEAT) begin
            state_next    = DONE;
            beat_cnt_next = '0;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (start_txn) begin
      beat_cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      beat_cnt_reg      <= '0;
      burst_address_reg <= '0;
      pmem_rdata_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      beat_cnt_reg <= beat_cnt_next;
      if (start_txn) begin
        burst_address_reg <= {pmem_address[31:OFFSET_W], {OFFSET_W{1'b0}}};
      end
      // The final beat goes straight into the visible line so it is
      // published whole on entry to DONE, never partially.
      if (last_read_beat) begin
        pmem_rdata_reg <= {burst_rdata, buf_line_q[LINE_W-BURST_W-1:0]};
      end
    end
  end

  assign burst_read    = (state_reg == READ);
  assign burst_write   = (state_reg == WRITE);
  assign pmem_resp     = (state_reg == DONE);
  assign burst_address = burst_address_reg;
  assign burst_wdata   = (state_reg == WRITE) ? buf_beat_q : '0;
  assign pmem_rdata    = pmem_rdata_reg;

  logic unused_bits;
  assign unused_bits = ^{pmem_address[OFFSET_W-1:0], buf_line_q[LINE_W-1 -: BURST_W]};

endmodule
